// File: rtl/interrogate_gen.sv
// Per-channel interrogate pulse generator: a synchronized reference edge schedules a
// WIDTH-cycle pulse DELAY cycles later, with a watchdog flagging a missing reference.
module interrogate_gen #(
    parameter int NCH     = 3,
    parameter int CW      = 11,
    parameter int DELAY   = 1608,
    parameter int WIDTH   = 15,
    parameter int TW      = 13,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   uref,
    input  logic [NCH-1:0]   en,
    input  logic [2*NCH-1:0] edge_mode,
    input  logic             fault_clr,
    output logic [NCH-1:0]   issihi,
    output logic [NCH-1:0]   iss_edge,
    output logic [NCH-1:0]   ref_fault
);

    if (!(NCH >= 1 && NCH <= 8 && WIDTH >= 1 && WIDTH < DELAY &&
          DELAY < (1 << CW) && TIMEOUT < (1 << TW))) begin : g_param_check
        $error("interrogate_gen: illegal parameter combination");
    end

    localparam logic [CW-1:0] DELAY_C   = CW'(DELAY);
    localparam logic [CW-1:0] WIDTH_C   = CW'(WIDTH);
    localparam logic [CW-1:0] ONE_C     = CW'(1);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

    logic [1:0]     prime_q, prime_d;
    logic           primed;
    logic [NCH-1:0] sync1_q, sync1_d;
    logic [NCH-1:0] sync2_q, sync2_d;
    logic [NCH-1:0] prev_q, prev_d;
    logic [NCH-1:0] rise, fall, xition, match, accept;
    logic [NCH-1:0] iss_edge_q, iss_edge_d;
    logic [NCH-1:0] ref_fault_q, ref_fault_d;
    logic [CW-1:0]  count_q [NCH];
    logic [CW-1:0]  count_d [NCH];
    logic [TW-1:0]  wd_q [NCH];
    logic [TW-1:0]  wd_d [NCH];

    // Priming blocks acceptance until the synchronizer has refilled after reset.
    assign primed = (prime_q == 2'd3);

    always_comb begin
        // NOTE: every signal gets a default before any conditional assignment, so no latches.
        prime_d     = primed ? prime_q : prime_q + 2'd1;
        sync1_d     = uref;
        sync2_d     = sync1_q;
        prev_d      = sync2_q;
        rise        = sync2_q & ~prev_q;
        fall        = ~sync2_q & prev_q;
        xition      = sync2_q ^ prev_q;
        match       = '0;
        accept      = '0;
        ref_fault_d = ref_fault_q;
        for (int i = 0; i < NCH; i++) begin
            count_d[i] = count_q[i];
            wd_d[i]    = wd_q[i];
            case (edge_mode[2*i +: 2])
                2'b00:   match[i] = xition[i];
                2'b01:   match[i] = rise[i];
                2'b10:   match[i] = fall[i];
                default: match[i] = 1'b0;
            endcase
            accept[i] = match[i] & en[i] & primed;

            if (!en[i])
                count_d[i] = '0;
            else if (accept[i])
                count_d[i] = DELAY_C;
            else if (count_q[i] != '0)
                count_d[i] = count_q[i] - ONE_C;

            // Watchdog sees transitions of either polarity regardless of edge_mode.
            if (fault_clr || !en[i] || !primed || xition[i])
                wd_d[i] = '0;
            else if (wd_q[i] < TIMEOUT_C)
                wd_d[i] = wd_q[i] + TW'(1);

            if (fault_clr)
                ref_fault_d[i] = 1'b0;
            else if (en[i] && wd_q[i] == TIMEOUT_C)
                ref_fault_d[i] = 1'b1;
        end
        iss_edge_d = accept;
    end

    always_comb begin
        issihi = '0;
        for (int i = 0; i < NCH; i++)
            issihi[i] = (count_q[i] >= ONE_C) && (count_q[i] <= WIDTH_C);
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            prime_q     <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            iss_edge_q  <= '0;
            ref_fault_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                count_q[i] <= '0;
                wd_q[i]    <= '0;
            end
        end else begin
            prime_q     <= prime_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            iss_edge_q  <= iss_edge_d;
            ref_fault_q <= ref_fault_d;
            for (int i = 0; i < NCH; i++) begin
                count_q[i] <= count_d[i];
                wd_q[i]    <= wd_d[i];
            end
        end
    end

    assign iss_edge  = iss_edge_q;
    assign ref_fault = ref_fault_q;

endmodule
